// File: rtl/seg_mux_driver.sv
// seg_mux_driver: time-multiplexed hex 7-segment driver with gap, PWM, dp, blanking and zero suppression
module seg_mux_driver #(
  parameter int DIGITS         = 4,
  parameter int DIV_LOG2       = 4,
  parameter int GAP            = 2,
  parameter int BRIGHT_W       = 2,
  parameter bit SEG_ACTIVE_LOW = 0,
  parameter bit DIG_ACTIVE_LOW = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            segs,
  output logic [DIGITS-1:0]     digit,
  output logic                  frame_start
);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hff : 8'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  logic                run;
  logic [DIV_LOG2-1:0] slot_cnt;
  logic [CW-1:0]       cdigit;
  logic [4*DIGITS-1:0] snap_value;
  logic [DIGITS-1:0]   snap_dp, snap_blank, sup;
  logic                snap_lz;
  logic                slot_wrap, frame_wrap, load, dark, pwm_on, on;
  logic [3:0]          nib;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   dig_next;

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 8'hfc;
      4'h1: enc = 8'h60;
      4'h2: enc = 8'hda;
      4'h3: enc = 8'hf2;
      4'h4: enc = 8'h66;
      4'h5: enc = 8'hb6;
      4'h6: enc = 8'hbe;
      4'h7: enc = 8'he0;
      4'h8: enc = 8'hfe;
      4'h9: enc = 8'hf6;
      4'ha: enc = 8'hee;
      4'hb: enc = 8'h3e;
      4'hc: enc = 8'h9c;
      4'hd: enc = 8'h7a;
      4'he: enc = 8'h9e;
      default: enc = 8'h8e;
    endcase
  endfunction

  // run stays low for the first edge after reset so that edge enters (0,0) and loads the snapshot
  assign slot_wrap  = &slot_cnt;
  assign frame_wrap = slot_wrap && cdigit == CW'(DIGITS - 1);
  assign load       = !run || frame_wrap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run        <= 1'b0;
      slot_cnt   <= '0;
      cdigit     <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lz    <= 1'b0;
    end else begin
      run      <= 1'b1;
      slot_cnt <= run ? slot_cnt + 1'b1 : '0;
      cdigit   <= load ? '0 : slot_wrap ? cdigit + 1'b1 : cdigit;
      if (load) begin
        snap_value <= value;
        snap_dp    <= dp;
        snap_blank <= blank;
        snap_lz    <= lz_blank;
      end
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_sup
    if (k == 0) begin : g_lsd
      assign sup[k] = 1'b0;
    end else begin : g_hi
      assign sup[k] = snap_lz && snap_value[4*DIGITS-1:4*k] == '0;
    end
  end

  always_comb begin
    nib      = snap_value[4*cdigit +: 4];
    dark     = snap_blank[cdigit] | sup[cdigit];
    pwm_on   = &brightness || slot_cnt[DIV_LOG2-1 -: BRIGHT_W] < brightness;
    on       = run && !dark && pwm_on && slot_cnt >= DIV_LOG2'(GAP);
    seg_next = run && !dark ? enc(nib) | {7'b0, snap_dp[cdigit]} : 8'h00;
    dig_next = on ? DIGITS'(1) << cdigit : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      segs        <= SEG_OFF;
      digit       <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      segs        <= seg_next ^ SEG_OFF;
      digit       <= dig_next ^ DIG_OFF;
      frame_start <= run && slot_cnt == '0 && cdigit == '0;
    end
  end
endmodule
